// File: rtl/task_graph_mapper.sv
// Streams an NUM_V x NUM_V adjacency matrix, ranks vertices by total row weight
// (largest first, ties to the lowest index) and assigns them to mesh tiles in rank order.
module task_graph_mapper #(
  parameter int NUM_V  = 4,
  parameter int W      = 32,
  parameter int MESH_X = 2,
  parameter int MESH_Y = 2,
  parameter int SNAKE  = 0,
  localparam int VW = $clog2(NUM_V),
  localparam int TW = $clog2(MESH_X*MESH_Y),
  localparam int SW = W + $clog2(NUM_V)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_weight,
  output logic          map_valid,
  input  logic          map_ready,
  output logic [VW-1:0] map_task,
  output logic [TW-1:0] map_tile,
  output logic          root_valid,
  output logic [VW-1:0] root_task,
  output logic          err_self_loop,
  output logic          done
);

  generate
    if (MESH_X*MESH_Y < NUM_V) begin : g_bad_mesh
      $error("task_graph_mapper: mesh has fewer tiles than task vertices");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD, SCAN, EMIT, DONE} state_t;

  localparam logic [VW-1:0] LAST_IDX  = VW'(NUM_V-1);
  localparam logic [VW:0]   LAST_RANK = (VW+1)'(NUM_V-1);
  localparam logic [TW-1:0] LAST_X    = TW'(MESH_X-1);
  localparam logic [TW-1:0] ROW_SPAN  = TW'(MESH_X);

  state_t           r_state, w_state_next;
  logic [VW-1:0]    r_row, r_col, r_scan, r_best, r_root_task;
  logic [SW-1:0]    r_total [NUM_V];
  logic [SW-1:0]    r_best_val;
  logic             r_best_found, r_root_valid, r_err;
  logic [NUM_V-1:0] r_mapped;
  logic [VW:0]      r_rank;
  logic [TW-1:0]    r_tx, r_ty, w_tx_eff;
  logic             w_accept, w_nonzero, w_last_beat, w_last_scan, w_last_rec, w_cand;

  assign w_accept    = in_valid & in_ready;
  assign w_nonzero   = (in_weight != '0);
  assign w_last_beat = (r_row == LAST_IDX) && (r_col == LAST_IDX);
  assign w_last_scan = (r_scan == LAST_IDX);
  assign w_last_rec  = (r_rank == LAST_RANK);
  // Strict '>' while scanning upwards keeps ties on the lowest index.
  assign w_cand = !r_mapped[r_scan] && (!r_best_found || (r_total[r_scan] > r_best_val));

  // Tile coordinates advance with rank; odd rows run right-to-left in snake order.
  assign w_tx_eff = ((SNAKE != 0) && r_ty[0]) ? (LAST_X - r_tx) : r_tx;

  assign map_task      = r_best;
  assign map_tile      = r_ty * ROW_SPAN + w_tx_eff;
  assign root_valid    = r_root_valid;
  assign root_task     = r_root_task;
  assign err_self_loop = r_err;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) r_state <= LOAD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    map_valid    = 1'b0;
    done         = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (w_accept && w_last_beat) w_state_next = SCAN;
      end
      SCAN: begin
        if (w_last_scan) w_state_next = EMIT;
      end
      EMIT: begin
        map_valid = 1'b1;
        if (map_ready) w_state_next = w_last_rec ? DONE : SCAN;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < NUM_V; i++) r_total[i] <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_scan       <= '0;
      r_best       <= '0;
      r_best_val   <= '0;
      r_best_found <= 1'b0;
      r_root_valid <= 1'b0;
      r_root_task  <= '0;
      r_err        <= 1'b0;
      r_mapped     <= '0;
      r_rank       <= '0;
      r_tx         <= '0;
      r_ty         <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_total[r_row] <= r_total[r_row] + SW'(in_weight);
            if (w_nonzero && !r_root_valid) begin
              r_root_valid <= 1'b1;
              r_root_task  <= r_row;
            end
            if (w_nonzero && (r_row == r_col)) r_err <= 1'b1;
            if (r_col == LAST_IDX) begin
              r_col <= '0;
              r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_last_beat) r_best_found <= 1'b0;
          end
        end
        SCAN: begin
          if (w_cand) begin
            r_best       <= r_scan;
            r_best_val   <= r_total[r_scan];
            r_best_found <= 1'b1;
          end
          r_scan <= w_last_scan ? '0 : r_scan + 1'b1;
        end
        EMIT: begin
          if (map_ready) begin
            r_mapped[r_best] <= 1'b1;
            r_rank           <= r_rank + 1'b1;
            r_best_found     <= 1'b0;
            if (r_tx == LAST_X) begin
              r_tx <= '0;
              r_ty <= r_ty + 1'b1;
            end else begin
              r_tx <= r_tx + 1'b1;
            end
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_V; i++) r_total[i] <= '0;
          r_row        <= '0;
          r_col        <= '0;
          r_scan       <= '0;
          r_best       <= '0;
          r_best_val   <= '0;
          r_best_found <= 1'b0;
          r_root_valid <= 1'b0;
          r_root_task  <= '0;
          r_err        <= 1'b0;
          r_mapped     <= '0;
          r_rank       <= '0;
          r_tx         <= '0;
          r_ty         <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_task_graph_mapper.sv
// Randomized scoreboard bench: two mappers (row-major and snake tile order) share one
// input stream; a reference model ranks vertices and a negedge monitor checks records.
module tb_task_graph_mapper;
  localparam int NUM_V  = 4;
  localparam int W      = 32;
  localparam int MESH_X = 2;
  localparam int MESH_Y = 2;
  localparam int VW     = $clog2(NUM_V);
  localparam int TW     = $clog2(MESH_X*MESH_Y);
  localparam int BEATS  = NUM_V*NUM_V;

  logic          clk = 1'b0;
  logic          rst_b, in_valid, map_ready;
  logic [W-1:0]  in_weight;
  logic          in_ready_a, map_valid_a, root_valid_a, err_a, done_a;
  logic [VW-1:0] task_a, root_task_a;
  logic [TW-1:0] tile_a;
  logic          in_ready_b, map_valid_b, root_valid_b, err_b, done_b;
  logic [VW-1:0] task_b, root_task_b;
  logic [TW-1:0] tile_b;

  task_graph_mapper #(.NUM_V(NUM_V), .W(W), .MESH_X(MESH_X), .MESH_Y(MESH_Y), .SNAKE(0)) u_dut_row (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_a), .in_weight(in_weight),
    .map_valid(map_valid_a), .map_ready(map_ready), .map_task(task_a), .map_tile(tile_a),
    .root_valid(root_valid_a), .root_task(root_task_a), .err_self_loop(err_a), .done(done_a));

  task_graph_mapper #(.NUM_V(NUM_V), .W(W), .MESH_X(MESH_X), .MESH_Y(MESH_Y), .SNAKE(1)) u_dut_snake (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready_b), .in_weight(in_weight),
    .map_valid(map_valid_b), .map_ready(map_ready), .map_task(task_b), .map_tile(tile_b),
    .root_valid(root_valid_b), .root_task(root_task_b), .err_self_loop(err_b), .done(done_b));

  initial forever #5 clk = ~clk;

  typedef struct {
    int tsk; int tile0; int tile1; bit root_v; int root_t; bit err; bit last;
  } rec_t;

  rec_t         exp_q[$];
  logic [W-1:0] mat [NUM_V][NUM_V];
  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt = 0;
  bit done_pend = 1'b0;
  bit lat_armed = 1'b0;
  int lat_cnt   = 0;
  int tb_beat   = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int snake_tile(input int r);
    int y, x;
    y = r / MESH_X;
    x = r % MESH_X;
    if (y % 2 == 1) x = MESH_X - 1 - x;
    return y * MESH_X + x;
  endfunction

  // Reference: row sums, then repeatedly take the heaviest unmapped vertex (lowest index on ties).
  task automatic push_expected();
    longint unsigned tot [NUM_V];
    bit used [NUM_V];
    bit rv = 0, er = 0;
    int rt = 0;
    rec_t e;
    for (int r = 0; r < NUM_V; r++) begin
      tot[r] = 0; used[r] = 0;
    end
    for (int r = 0; r < NUM_V; r++)
      for (int c = 0; c < NUM_V; c++) begin
        tot[r] += longint'(mat[r][c]);
        if (mat[r][c] != 0 && !rv) begin rv = 1; rt = r; end
        if (mat[r][c] != 0 && r == c) er = 1;
      end
    for (int rank = 0; rank < NUM_V; rank++) begin
      int best = -1;
      for (int v = 0; v < NUM_V; v++)
        if (!used[v] && (best < 0 || tot[v] > tot[best])) best = v;
      used[best] = 1;
      e.tsk = best; e.tile0 = rank; e.tile1 = snake_tile(rank);
      e.root_v = rv; e.root_t = rt; e.err = er; e.last = (rank == NUM_V - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_req36();
    int rows [4][4] = '{'{0,0,0,7}, '{0,0,6,0}, '{0,6,0,5}, '{7,0,5,0}};
    for (int r = 0; r < NUM_V; r++)
      for (int c = 0; c < NUM_V; c++) mat[r][c] = W'(rows[r][c]);
  endtask

  task automatic load_fill(input int mode);
    for (int r = 0; r < NUM_V; r++)
      for (int c = 0; c < NUM_V; c++)
        case (mode)
          0: mat[r][c] = '0;
          1: mat[r][c] = W'($urandom_range(0, 3));
          2: mat[r][c] = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
          default: mat[r][c] = W'($urandom);
        endcase
  endtask

  // Inputs change 1 time unit after a rising edge; the monitor samples on falling edges.
  task automatic send_beat(input logic [W-1:0] w, input bit gaps);
    bit rdy;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0; in_weight = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_weight = w;
    for (int t = 0; ; t++) begin
      rdy = in_ready_a;
      @(posedge clk); #1;
      if (rdy) break;
      if (t > 300) begin
        check(1'b0, "in_ready_timeout", $sformatf("in_ready=%0d after %0d cycles, required 1", in_ready_a, t));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int n_beats, input bit push);
    for (int k = 0; k < n_beats; k++) send_beat(mat[k / NUM_V][k % NUM_V], gaps);
    if (push) push_expected();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || done_pend) && t < 600) begin
      @(posedge clk); #1; t++;
    end
    check(exp_q.size() == 0 && !done_pend, "drain",
          $sformatf("pending records=%0d done_pending=%0d, required 0/0", exp_q.size(), done_pend));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_b    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(in_ready_a && in_ready_b && !map_valid_a && !map_valid_b && !root_valid_a && !root_valid_b &&
          !err_a && !err_b && !done_a && !done_b && task_a == 0 && tile_a == 0 && task_b == 0 && tile_b == 0,
          "reset_outputs",
          $sformatf("rdy=%0d mv=%0d rv=%0d err=%0d done=%0d task=%0d tile=%0d, required rdy=1 others 0",
                    in_ready_a, map_valid_a, root_valid_a, err_a, done_a, task_a, tile_a));
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    check(in_ready_a && in_ready_b, "in_ready_after_release",
          $sformatf("in_ready=%0d/%0d, required 1", in_ready_a, in_ready_b));
    @(posedge clk); #1;
  endtask

  // Consumer side: optional forced stall on the next record, otherwise random backpressure.
  initial begin
    map_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        map_ready = 1'b0;
        if (map_valid_a) stall_cnt--;
      end else begin
        map_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      tb_beat = 0; lat_armed = 0; done_pend = 0;
    end else begin
      if (done_a || done_b || done_pend)
        check(done_a == done_pend && done_b == done_pend, "done_pulse",
              $sformatf("done=%0d/%0d, required %0d", done_a, done_b, done_pend));
      done_pend = 0;
      if (lat_armed) lat_cnt++;
      if (lat_armed && map_valid_a) begin
        check(lat_cnt == NUM_V + 1, "first_record_latency",
              $sformatf("latency=%0d cycles, required %0d", lat_cnt, NUM_V + 1));
        lat_armed = 0;
      end
      if (in_valid && in_ready_a) begin
        if (tb_beat == BEATS - 1) begin
          lat_armed = 1; lat_cnt = 0; tb_beat = 0;
        end else begin
          tb_beat++;
        end
      end
      if (map_valid_a || map_valid_b) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_record",
                $sformatf("record task=%0d tile=%0d presented, required none", task_a, tile_a));
        end else begin
          rec_t e;
          e = exp_q[0];
          check(map_valid_a && map_valid_b && int'(task_a) == e.tsk && int'(task_b) == e.tsk &&
                int'(tile_a) == e.tile0 && int'(tile_b) == e.tile1 &&
                root_valid_a == e.root_v && root_valid_b == e.root_v &&
                (!e.root_v || (int'(root_task_a) == e.root_t && int'(root_task_b) == e.root_t)) &&
                err_a == e.err && err_b == e.err,
                "record",
                $sformatf("got task=%0d/%0d tile=%0d/%0d root=%0d:%0d err=%0d; required task=%0d tile=%0d/%0d root=%0d:%0d err=%0d",
                          task_a, task_b, tile_a, tile_b, root_valid_a, root_task_a, err_a,
                          e.tsk, e.tile0, e.tile1, e.root_v, e.root_t, e.err));
          if (map_ready) begin
            $display("record task=%0d tile=%0d snake_tile=%0d root=%0d:%0d err=%0d",
                     task_a, tile_a, tile_b, root_valid_a, root_task_a, err_a);
            void'(exp_q.pop_front());
            if (e.last) done_pend = 1;
          end
        end
      end
    end
  end

  initial begin
    rst_b = 1'b1; in_valid = 1'b0; in_weight = '0;
    #1;
    do_reset();

    load_req36();  send_frame(1'b0, BEATS, 1'b1); wait_idle();
    stall_cnt = 5; send_frame(1'b1, BEATS, 1'b1); wait_idle();
    load_fill(0);  send_frame(1'b0, BEATS, 1'b1); wait_idle();
    load_fill(0);  mat[2][2] = W'(9); send_frame(1'b0, BEATS, 1'b1); wait_idle();

    load_req36();  send_frame(1'b1, 5, 1'b0);
    do_reset();
    send_frame(1'b0, BEATS, 1'b1); wait_idle();

    load_fill(3);  send_frame(1'b0, BEATS, 1'b0);
    do_reset();
    repeat (NUM_V + 4) @(posedge clk);
    #1;
    load_req36();  send_frame(1'b1, BEATS, 1'b1); wait_idle();

    for (int f = 0; f < 24; f++) begin
      load_fill(1 + (f % 3));
      send_frame(bit'($urandom_range(0, 1)), BEATS, 1'b1);
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/task_graph_mapper.md
TASK_GRAPH_MAPPER -- requirements
Module: task_graph_mapper

Interface
REQ-001 SHALL have parameter NUM_V, default 4, meaning number of task vertices (>=2).
REQ-002 SHALL have parameter W, default 32, meaning edge-weight width in bits.
REQ-003 SHALL have parameter MESH_X, default 2, meaning mesh tile columns.
REQ-004 SHALL have parameter MESH_Y, default 2, meaning mesh tile rows; MESH_X*MESH_Y >= NUM_V, else elaboration error.
REQ-005 SHALL have parameter SNAKE, default 0, meaning tile order: 0 row-major, 1 boustrophedon.
REQ-006 Derived widths: VW = clog2(NUM_V), TW = clog2(MESH_X*MESH_Y), SW = W+clog2(NUM_V).
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port rst_b  input  1  reset, asynchronous assert, active-high (1 = reset), synchronous release.
REQ-009 SHALL have port in_valid  input  1  matrix element valid.
REQ-010 SHALL have port in_ready  output  1  block accepts an element.
REQ-011 SHALL have port in_weight  input  W  adjacency element, row-major order.
REQ-012 SHALL have port map_valid  output  1  mapping record valid.
REQ-013 SHALL have port map_ready  input  1  consumer accepts the record.
REQ-014 SHALL have port map_task  output  VW  task index of the record.
REQ-015 SHALL have port map_tile  output  TW  tile assigned to map_task.
REQ-016 SHALL have port root_valid  output  1  a nonzero element was seen this frame.
REQ-017 SHALL have port root_task  output  VW  row of the first nonzero element of the frame.
REQ-018 SHALL have port err_self_loop  output  1  a nonzero diagonal element was seen this frame.
REQ-019 SHALL have port done  output  1  one-cycle pulse after the last record is accepted.

Function
REQ-020 FSM states LOAD, SCAN, EMIT, DONE; the state after reset is LOAD.
REQ-021 LOAD: in_ready=1; a beat is accepted when in_valid&in_ready; beat k carries row k/NUM_V, column k%NUM_V, with row/col generated internally.
REQ-022 Each accepted beat SHALL add in_weight to total[row]; totals are SW bits wide and never overflow.
REQ-023 First accepted nonzero beat of a frame SHALL set root_valid=1 and root_task=row; both then hold until the next frame starts.
REQ-024 Accepted nonzero beat with row==col SHALL set err_self_loop=1, sticky until the next frame; the weight is still accumulated.
REQ-025 After beat NUM_V*NUM_V-1 is accepted, the FSM SHALL go to SCAN on the next cycle with in_ready=0.
REQ-026 SCAN SHALL examine one vertex per cycle for NUM_V cycles and select the unmapped vertex with the largest total; ties go to the lowest index.
REQ-027 After SCAN the FSM SHALL go to EMIT: map_valid=1, map_task=selection, map_tile=tile(rank), where rank = number of records already emitted.
REQ-028 tile(r) with SNAKE=0 SHALL be r; with SNAKE=1, y=r/MESH_X, x=r%MESH_X, mirrored to MESH_X-1-x when y is odd, and tile=y*MESH_X+x.
REQ-029 map_task/map_tile SHALL stay stable while map_valid&!map_ready; a record is consumed when map_valid&map_ready.
REQ-030 On consume: mark the vertex mapped, rank+1; the FSM goes to SCAN if rank<NUM_V, else to DONE.
REQ-031 DONE SHALL last exactly one cycle with done=1, then go to LOAD; this clears the totals, the mapped flags, rank, beat counter, root_valid and err_self_loop.
REQ-032 Latency from the last input beat to the first map_valid SHALL be NUM_V+1 cycles.
REQ-033 An all-zero matrix SHALL map vertices in index order 0..NUM_V-1 with root_valid=0.

Reset
REQ-034 While rst_b=1, all outputs SHALL be 0 except in_ready, and all counters, totals and flags SHALL be cleared.
REQ-035 After rst_b falls, in_ready SHALL be 1 on the first cycle; rst_b asserted mid-frame in any state SHALL discard the frame, and no partial record or done pulse is produced.

Verification (defaults, SNAKE=0 unless stated)
REQ-036 Stream rows {0,0,0,7},{0,0,6,0},{0,6,0,5},{7,0,5,0} -> totals 7,6,11,12; records (3,0),(2,1),(0,2),(1,3); root_task=0, err_self_loop=0, one done pulse.
REQ-037 Same stream with SNAKE=1 -> records (3,0),(2,1),(0,3),(1,2).
REQ-038 All-zero matrix -> records (0,0),(1,1),(2,2),(3,3); root_valid=0.
REQ-039 Element [2][2]=9, all others zero -> err_self_loop=1, root_task=2, first record is (2,0).
REQ-040 Hold map_ready=0 for 5 cycles on the first record; hold in_valid low randomly -> outputs stable, no beat lost, identical records.
REQ-041 Assert rst_b after 5 beats, then stream the REQ-036 frame -> results match REQ-036 exactly.
